// File: rtl/abies_sram_pkg.sv
// rtl/abies_sram_pkg.sv - shared SRAM ramp types and expected-value helper
// Used by both the ramp loader and the ramp read-back checker.
package abies_sram_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_ISSUE = 2'd1,
    CHK_DRAIN = 2'd2,
    CHK_DONE  = 2'd3
  } chk_state_e;

  localparam int RAMP_MAX_W = 32;

  // Ramp word for an address is its top dw bits; callers truncate to dw.
  function automatic logic [RAMP_MAX_W-1:0] ramp_expected(
    input logic [RAMP_MAX_W-1:0] addr,
    input int                    aw,
    input int                    dw
  );
    return addr >> (aw - dw);
  endfunction

endpackage

// File: rtl/sram_ramp_checker_if.sv
// rtl/sram_ramp_checker_if.sv - arbiter client port used by the ramp checker
// master = checker side (drives requests), slave = arbiter/SRAM side.
interface sram_ramp_checker_if #(
  parameter int AW = 19,
  parameter int DW = 8
) ();
  logic [AW-1:0] addra;
  logic          ena;
  logic          wea;
  logic          busya;
  logic          valida;
  logic [DW-1:0] data_rd;

  modport master (output addra, ena, wea, input busya, valida, data_rd);
  modport slave  (input addra, ena, wea, output busya, valida, data_rd);
endinterface

// File: rtl/sram_ramp_checker_fifo.sv
// rtl/sram_ramp_checker_fifo.sv - in-flight address FIFO for the ramp checker
// Holds addresses of accepted reads until their in-order response returns.
module ramp_check_fifo #(
  parameter  int W     = 19,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;

endmodule

// File: rtl/sram_ramp_checker.sv
// rtl/sram_ramp_checker.sv - read-only sweep that verifies the SRAM ramp pattern
// Optional SRAM_RAMP_CHECK_STOP_ON_ERR_EN: stop issuing at the first mismatch.
module sram_ramp_checker
  import abies_sram_pkg::*;
#(
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int MAX_OUT = 4,
  parameter int ERRW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRW-1:0]     err_count,
  output logic                first_err_valid,
  output logic [AW-1:0]       first_err_addr,
  output logic [DW-1:0]       first_err_data,
  sram_ramp_checker_if.master sram
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [AW-1:0] ADDR_LAST = '1;
`ifdef SRAM_RAMP_CHECK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  chk_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [ERRW-1:0] err_q, err_d;
  logic          fev_q, fev_d;
  logic [AW-1:0] fea_q, fea_d;
  logic [DW-1:0] fed_q, fed_d;
  logic          pass_q, pass_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic          cmp_err_q, cmp_err_d;
  logic          cmp_stray_q, cmp_stray_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [DW-1:0] cmp_data_q, cmp_data_d;

  logic          active, resp_take, resp_pop, stray, mismatch_now;
  logic          ena_c, accept;
  logic [AW-1:0] fifo_head;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] head_expected;

  ramp_check_fifo #(.W(AW), .DEPTH(MAX_OUT)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (addr_q),
    .pop       (resp_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (outstanding)
  );

  // Responses are only meaningful while a sweep is running; IDLE/DONE ignore them.
  always_comb begin
    active        = (state_q == CHK_ISSUE) || (state_q == CHK_DRAIN);
    resp_take     = sram.valida && active;
    resp_pop      = resp_take && !fifo_empty;
    stray         = resp_take && fifo_empty;
    head_expected = DW'(ramp_expected(RAMP_MAX_W'(fifo_head), AW, DW));
    mismatch_now  = resp_pop && (sram.data_rd != head_expected);
    ena_c         = (state_q == CHK_ISSUE) && !fifo_full;
    accept        = ena_c && !sram.busya;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    err_d       = err_q;
    fev_d       = fev_q;
    fea_d       = fea_q;
    fed_d       = fed_q;
    pass_d      = pass_q;
    cmp_vld_d   = resp_take;
    cmp_err_d   = mismatch_now || stray;
    cmp_stray_d = stray;
    cmp_addr_d  = fifo_head;
    cmp_data_d  = sram.data_rd;

    // Registered compare result lands one cycle after valida.
    if (cmp_vld_q && cmp_err_q) begin
      if (err_q != '1) err_d = err_q + ERRW'(1);
      if (!cmp_stray_q && !fev_q) begin
        fev_d = 1'b1;
        fea_d = cmp_addr_q;
        fed_d = cmp_data_q;
      end
    end

    case (state_q)
      CHK_IDLE, CHK_DONE: begin
        if (start) begin
          state_d = CHK_ISSUE;
          addr_d  = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          fed_d   = '0;
          pass_d  = 1'b0;
        end
      end
      CHK_ISSUE: begin
        if (accept) begin
          if (addr_q == ADDR_LAST) state_d = CHK_DRAIN;
          else                     addr_d  = addr_q + AW'(1);
        end
        if (STOP_ON_ERR && mismatch_now) state_d = CHK_DRAIN;
      end
      CHK_DRAIN: begin
        // Wait until every response is popped and its compare has retired.
        if ((outstanding == '0) && !cmp_vld_q && !resp_take) begin
          state_d = CHK_DONE;
          pass_d  = (err_q == '0);
        end
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CHK_IDLE;
      addr_q      <= '0;
      err_q       <= '0;
      fev_q       <= 1'b0;
      fea_q       <= '0;
      fed_q       <= '0;
      pass_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_err_q   <= 1'b0;
      cmp_stray_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      fev_q       <= fev_d;
      fea_q       <= fea_d;
      fed_q       <= fed_d;
      pass_q      <= pass_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_err_q   <= cmp_err_d;
      cmp_stray_q <= cmp_stray_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_data_q  <= cmp_data_d;
    end
  end

  assign busy            = active;
  assign done            = (state_q == CHK_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;
  assign first_err_data  = fed_q;
  assign sram.addra      = addr_q;
  assign sram.ena        = ena_c;
  assign sram.wea        = 1'b0;

endmodule
